// File: rtl/shift_arbiter.sv
// shift_arbiter: two-port valid/ready arbiter in front of a shared barrel
// shifter, with a one-entry tagged response register.
// Build option: define SHIFT_ARB_RR_EN for round-robin tie breaking;
// leave it undefined for fixed priority (port 0 wins every tie).
module shift_arbiter #(
  parameter logic [1:0] LEFT_SHIFT             = 2'b00,
  parameter logic [1:0] RIGHT_LOGIC_SHIFT      = 2'b01,
  parameter logic [1:0] RIGHT_ARITHMETIC_SHIFT = 2'b10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_op_a_i,
  input  logic [31:0] req0_op_b_i,
  input  logic [1:0]  req0_opcode_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_op_a_i,
  input  logic [31:0] req1_op_b_i,
  input  logic [1:0]  req1_opcode_i,
  output logic [31:0] sh_op_a_o,
  output logic [31:0] sh_op_b_o,
  output logic [1:0]  sh_opcode_o,
  input  logic [31:0] sh_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  logic        can_accept;
  logic        tie_pick1;
  logic        grant0;
  logic        grant1;
  logic [31:0] sel_op_a;
  logic [31:0] sel_op_b;
  logic [1:0]  sel_opcode;

`ifdef SHIFT_ARB_RR_EN
  // Last granted ID; resets to 1 so port 0 takes the first tie.
  logic rr_ptr;
  assign tie_pick1 = ~rr_ptr;
`else
  assign tie_pick1 = 1'b0;
`endif

  // The slot is free when empty or when the held result leaves this cycle.
  // Nothing is granted while reset is asserted.
  assign can_accept = rst_n_i && ((state == EMPTY) || rsp_ready_i);

  assign grant0 = can_accept && req0_valid_i && (!req1_valid_i || !tie_pick1);
  assign grant1 = can_accept && req1_valid_i && (!req0_valid_i ||  tie_pick1);

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Steer the granted payload to the shifter; idle inputs are all-zero.
  always_comb begin
    sel_op_a   = '0;
    sel_op_b   = '0;
    sel_opcode = '0;
    if (grant0) begin
      sel_op_a   = req0_op_a_i;
      sel_op_b   = req0_op_b_i;
      sel_opcode = req0_opcode_i;
    end else if (grant1) begin
      sel_op_a   = req1_op_a_i;
      sel_op_b   = req1_op_b_i;
      sel_opcode = req1_opcode_i;
    end
  end

  assign sh_op_a_o = sel_op_a;
  assign sh_op_b_o = sel_op_b;

  // Opcodes are forwarded unchanged; unknown codes fall through as-is so the
  // shifter itself produces the zero result.
  always_comb begin
    case (sel_opcode)
      LEFT_SHIFT:             sh_opcode_o = LEFT_SHIFT;
      RIGHT_LOGIC_SHIFT:      sh_opcode_o = RIGHT_LOGIC_SHIFT;
      RIGHT_ARITHMETIC_SHIFT: sh_opcode_o = RIGHT_ARITHMETIC_SHIFT;
      default:                sh_opcode_o = sel_opcode;
    endcase
  end

  // Response register FSM: capture on grant, drain on consumer ready.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= EMPTY;
      rsp_id_o     <= 1'b0;
      rsp_result_o <= 32'h0;
`ifdef SHIFT_ARB_RR_EN
      rr_ptr       <= 1'b1;
`endif
    end else begin
      if (grant0 || grant1) begin
        state        <= FULL;
        rsp_id_o     <= grant1;
        rsp_result_o <= sh_result_i;
`ifdef SHIFT_ARB_RR_EN
        rr_ptr       <= grant1;
`endif
      end else if (state == FULL && rsp_ready_i) begin
        state <= EMPTY;
      end
    end
  end

  assign rsp_valid_o = (state == FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: directed cases plus random traffic, with an
// expected-response queue drained by an independent monitor.
module tb_shift_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_op_a_i = '0, req0_op_b_i = '0, req1_op_a_i = '0, req1_op_b_i = '0;
  logic [1:0]  req0_opcode_i = '0, req1_opcode_i = '0;
  logic [31:0] sh_op_a_o, sh_op_b_o, sh_result_i;
  logic [1:0]  sh_opcode_o;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_id_o;
  logic [31:0] rsp_result_o;

  int compared = 0;
  int mismatched = 0;

  logic [32:0] exp_q[$];   // {id, result}
  bit hold0 = 0, hold1 = 0; // request presented and not yet accepted
  bit m_full = 0;           // model: response slot occupied
  bit m_last = 1;           // model: last granted port

  always #5 clk_i = ~clk_i;

  shift_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_op_a_i(req0_op_a_i), .req0_op_b_i(req0_op_b_i), .req0_opcode_i(req0_opcode_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_op_a_i(req1_op_a_i), .req1_op_b_i(req1_op_b_i), .req1_opcode_i(req1_opcode_i),
    .sh_op_a_o(sh_op_a_o), .sh_op_b_o(sh_op_b_o), .sh_opcode_o(sh_opcode_o),
    .sh_result_i(sh_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o)
  );

  // Shared shifter as seen by the block (environment, not the reference)
  always_comb begin
    case (sh_opcode_o)
      2'b00:   sh_result_i = sh_op_a_o << sh_op_b_o[4:0];
      2'b01:   sh_result_i = sh_op_a_o >> sh_op_b_o[4:0];
      2'b10:   sh_result_i = $unsigned($signed(sh_op_a_o) >>> sh_op_b_o[4:0]);
      default: sh_result_i = 32'h0;
    endcase
  end

  // Reference result computed with plain arithmetic on powers of two
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    longint unsigned p;
    longint unsigned ua;
    p  = 64'd1 << b[4:0];
    ua = {32'h0, a};
    case (op)
      2'b00: return 32'((ua * p) % (64'd1 << 32));
      2'b01: return 32'(ua / p);
      2'b10: return a[31] ? ~32'(({32'h0, ~a}) / p) : 32'(ua / p);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: present new requests on idle ports, predict grant,
  // check handshake and shifter mux, queue the expected response.
  task automatic drive_cycle(input bit n0, input logic [31:0] a0, input logic [31:0] b0,
                             input logic [1:0] o0, input bit n1, input logic [31:0] a1,
                             input logic [31:0] b1, input logic [1:0] o1, input bit rdy);
    bit can, win1, g0, g1;
    logic [31:0] ea, eb;
    logic [1:0]  eo;
    @(negedge clk_i);
    if (!hold0) begin
      if (n0) begin
        req0_valid_i = 1; req0_op_a_i = a0; req0_op_b_i = b0; req0_opcode_i = o0; hold0 = 1;
      end else begin
        req0_valid_i = 0; req0_op_a_i = $urandom;
      end
    end
    if (!hold1) begin
      if (n1) begin
        req1_valid_i = 1; req1_op_a_i = a1; req1_op_b_i = b1; req1_opcode_i = o1; hold1 = 1;
      end else begin
        req1_valid_i = 0; req1_op_a_i = $urandom;
      end
    end
    rsp_ready_i = rdy;
    #2;
    can = !m_full || rdy;
`ifdef SHIFT_ARB_RR_EN
    win1 = (m_last == 1'b0);
`else
    win1 = 1'b0;
`endif
    g0 = can && hold0 && (!hold1 || !win1);
    g1 = can && hold1 && (!hold0 || win1);
    chk("req0_ready", {63'h0, req0_ready_o}, {63'h0, g0});
    chk("req1_ready", {63'h0, req1_ready_o}, {63'h0, g1});
    chk("rsp_valid", {63'h0, rsp_valid_o}, {63'h0, m_full});
    ea = '0; eb = '0; eo = '0;
    if (g0) begin
      ea = req0_op_a_i; eb = req0_op_b_i; eo = req0_opcode_i;
      exp_q.push_back({1'b0, ref_shift(req0_op_a_i, req0_op_b_i, req0_opcode_i)});
    end else if (g1) begin
      ea = req1_op_a_i; eb = req1_op_b_i; eo = req1_opcode_i;
      exp_q.push_back({1'b1, ref_shift(req1_op_a_i, req1_op_b_i, req1_opcode_i)});
    end
    chk("sh_mux", {sh_op_a_o, sh_op_b_o[29:0], sh_opcode_o}, {ea, eb[29:0], eo});
    @(posedge clk_i);
    if (g0 || g1) begin
      m_full = 1; m_last = g1;
      if (g0) hold0 = 0; else hold1 = 0;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
  endtask

  // Directed check of the response register right after an edge
  task automatic expect_now(input string name, input logic id, input logic [31:0] res);
    #1;
    chk({name, "_valid"}, {63'h0, rsp_valid_o}, 64'h1);
    chk({name, "_id"}, {63'h0, rsp_id_o}, {63'h0, id});
    chk({name, "_result"}, {32'h0, rsp_result_o}, {32'h0, res});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 0; rsp_ready_i = 0; req0_valid_i = 1; req1_valid_i = 1;
    hold0 = 0; hold1 = 0;
    #2;
    chk("rst_no_grant0", {63'h0, req0_ready_o}, 64'h0);
    chk("rst_no_grant1", {63'h0, req1_ready_o}, 64'h0);
    @(posedge clk_i); #1;
    chk("rst_valid", {63'h0, rsp_valid_o}, 64'h0);
    chk("rst_id", {63'h0, rsp_id_o}, 64'h0);
    chk("rst_result", {32'h0, rsp_result_o}, 64'h0);
    @(negedge clk_i);
    rst_n_i = 1; req0_valid_i = 0; req1_valid_i = 0;
    exp_q.delete(); m_full = 0; m_last = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: whenever a response is consumed, compare it with the queue head
  always @(negedge clk_i) begin
    logic [32:0] e;
    #3;
    if (rst_n_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {31'h0, rsp_id_o, rsp_result_o}, 64'h1_0000_0000_0000);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", {31'h0, rsp_id_o, rsp_result_o}, {31'h0, e});
        $display("rsp id=%0d result=%08h", rsp_id_o, rsp_result_o);
      end
    end
  end

  initial begin
    do_reset();

    // Single left shift on port 0
    drive_cycle(1, 32'h1, 32'd4, 2'b00, 0, 0, 0, 0, 1);
    expect_now("single", 1'b0, 32'h0000_0010);
    // Arithmetic right shift on port 1, amount from op_b[4:0] only
    drive_cycle(0, 0, 0, 0, 1, 32'h8000_0000, 32'h24, 2'b10, 1);
    expect_now("arith", 1'b1, 32'hF800_0000);
    idle(2);

    // Tie for four cycles
    for (int i = 0; i < 4; i++)
      drive_cycle(1, 32'h10 + i, i, 2'b00, 1, 32'h100 + i, i, 2'b01, 1);
    idle(6);

    // Backpressure: slot full, consumer stalled
    drive_cycle(1, 32'h5, 32'd1, 2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 32'h3, 32'd2, 2'b00, 0, 0, 0, 0, 0);
      #1 chk("bp_hold", {32'h0, rsp_result_o}, 64'hA);
    end
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_now("bp_release", 1'b0, 32'h0000_000C);
    idle(2);

    // Unknown opcode
    drive_cycle(1, 32'hFFFF_FFFF, 32'd3, 2'b11, 0, 0, 0, 0, 1);
    expect_now("unknown_op", 1'b0, 32'h0);
    idle(2);

    // Reset while a response is stalled
    drive_cycle(0, 0, 0, 0, 1, 32'h7, 32'd1, 2'b00, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    drive_cycle(1, 32'h9, 32'd0, 2'b01, 1, 32'h6, 32'd0, 2'b01, 1);
    expect_now("post_rst_tie", 1'b0, 32'h9);
    idle(3);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      drive_cycle($urandom_range(0, 1), $urandom, $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1), $urandom, $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0);
    idle(6);
    #1;
    chk("drain_queue", 64'(exp_q.size()), 64'h0);
    chk("drain_valid", {63'h0, rsp_valid_o}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester arbiter and sequencer for the ALU's shared barrel-shift datapath. It accepts shift requests from two independent issue ports over valid/ready handshakes and grants one per cycle. It drives the granted operands onto the shared shifter's combinational inputs and captures the shifter result into a one-entry response register, tagged with the requester ID. It sits between the issue stage and the shared shifter, so the execute stage needs only one shifter instance for both pipes.

## Interface
Parameters:
- `LEFT_SHIFT`, default 2'b00: opcode for logical left shift, passed through unchanged.
- `RIGHT_LOGIC_SHIFT`, default 2'b01: opcode for logical right shift.
- `RIGHT_ARITHMETIC_SHIFT`, default 2'b10: opcode for arithmetic right shift; 2'b11 is the unknown opcode and yields result 0 from the shifter.

Ports:
- `clk_i` input 1: single clock, rising edge.
- `rst_n_i` input 1: reset, synchronous, active-low.
- `req0_valid_i` / `req1_valid_i` input 1: request present on port 0 / port 1.
- `req0_ready_o` / `req1_ready_o` output 1: request accepted this cycle.
- `req0_op_a_i` / `req1_op_a_i` input 32: shift operand.
- `req0_op_b_i` / `req1_op_b_i` input 32: shift amount; only [4:0] is used.
- `req0_opcode_i` / `req1_opcode_i` input 2: shift opcode.
- `sh_op_a_o` output 32: operand to the shared shifter.
- `sh_op_b_o` output 32: shift amount to the shared shifter.
- `sh_opcode_o` output 2: opcode to the shared shifter.
- `sh_result_i` input 32: combinational result from the shared shifter.
- `rsp_valid_o` output 1: response register holds a result.
- `rsp_ready_i` input 1: consumer takes the response this cycle.
- `rsp_id_o` output 1: requester that owns the response (0 or 1).
- `rsp_result_o` output 32: registered shift result.

## Operation
- FSM with two states: EMPTY (response register invalid) and FULL (response register valid).
- `can_accept` = EMPTY, or (FULL and `rsp_ready_i`).
- Grant selection is combinational. If `can_accept` is 0, there is no grant. Otherwise:
  - Only one valid: grant that one.
  - Both valid: apply the policy in Configuration.
- `reqN_ready_o` = grant to N. At most one ready is high per cycle.
- Shifter mux outputs:
  - Granted port's `op_a`, `op_b` and `opcode` appear on the `sh_*` outputs in the same cycle.
  - With no grant, `sh_*` are driven to 0 (opcode 2'b00).
- On a grant, at the clock edge: `rsp_result_o` <= `sh_result_i`, `rsp_id_o` <= granted ID, state becomes FULL.
- FULL with `rsp_ready_i` and no new grant: state becomes EMPTY; `rsp_result_o` and `rsp_id_o` hold their last values.
- FULL with `rsp_ready_i` and a new grant: state stays FULL and the register is overwritten. This is back-to-back throughput of one per cycle.
- FULL without `rsp_ready_i`: the register holds and both readies are 0 (backpressure).
- Opcode 2'b11 is not rejected. It is forwarded as-is and returns result 0.
- The block does no arithmetic itself; widths pass through unchanged.

## Timing
- Reset values (synchronous, `rst_n_i`=0 at an edge): state EMPTY, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_result_o`=32'h0, round-robin pointer = 1 (so port 0 wins the first tie).
- Latency: request accepted at edge N gives `rsp_valid_o`=1 from after edge N to edge N+1.
- Throughput: one result per cycle while `rsp_ready_i`=1 and requests are pending.
- `reqN_ready_o` depends combinationally on `reqN_valid_i`, `rsp_ready_i` and state. The `sh_*` outputs depend combinationally on the request inputs.
- A requester must hold valid and payload stable until ready is seen. A deasserted valid is never granted.
- Reset mid-operation: a pending response is discarded, `rsp_valid_o` drops after the reset edge, and no grant is given while `rst_n_i`=0.

## Configuration
- `SHIFT_ARB_RR_EN` defined: round-robin.
  - A 1-bit pointer records the last granted ID and updates on every grant.
  - On a tie, the port other than the pointer wins.
- `SHIFT_ARB_RR_EN` undefined: fixed priority.
  - Port 0 always wins a tie; port 1 can starve.
  - No pointer register is built.

## Test plan
- Single request: port 0 sends op_a=32'h00000001, op_b=4, opcode=00 → `req0_ready_o`=1 the same cycle; next cycle `rsp_valid_o`=1, `rsp_id_o`=0, `rsp_result_o`=32'h00000010.
- Arithmetic shift: port 1 sends op_a=32'h80000000, op_b=32'h00000024 (amount 4), opcode=10 → `rsp_result_o`=32'hF8000000, `rsp_id_o`=1.
- Tie, `SHIFT_ARB_RR_EN` defined: both ports hold valid for 4 cycles with `rsp_ready_i`=1 → grants go 0,1,0,1. With the macro undefined, port 0 takes all 4 grants.
- Backpressure: response FULL and `rsp_ready_i`=0 for 3 cycles with port 0 valid → both readies stay 0 and the result holds. When `rsp_ready_i` rises, the new grant happens in the same cycle and the register is overwritten.
- Unknown opcode: opcode=11, op_a=32'hFFFFFFFF → `rsp_result_o`=32'h0 with `rsp_valid_o`=1.
- Reset mid-operation: assert `rst_n_i`=0 while FULL with `rsp_ready_i`=0 → after the edge `rsp_valid_o`=0 and `rsp_result_o`=0. After release, the next tie goes to port 0.
